// File: rtl/lwe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// lwe_cmd_sequencer : in-order host command FIFO feeding the LWE controller,
//                     one command in flight, watchdog-guarded completion.
// Revision 1.0
// ============================================================================
module lwe_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int DEPTH_WIDTH    = 2,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // host command channel
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_opcode,
  input  logic [ADDR_WIDTH-1:0]  cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0]  cmd_op2_addr,
  input  logic [TAG_WIDTH-1:0]   cmd_tag,
  // controller side
  output logic                   ctrl_config_en,
  output logic [1:0]             ctrl_opcode,
  output logic [ADDR_WIDTH-1:0]  ctrl_op1_base_addr,
  output logic [ADDR_WIDTH-1:0]  ctrl_op2_base_addr,
  input  logic                   ctrl_done,
  // host response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  output logic [1:0]             rsp_opcode,
  output logic                   rsp_timeout,
  // status
  output logic                   busy,
  output logic [DEPTH_WIDTH:0]   queue_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] op1;
    logic [ADDR_WIDTH-1:0] op2;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  localparam logic [DEPTH_WIDTH:0]     FULL_COUNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX     = '1;
  localparam bit                       WD_ENABLE  = (TIMEOUT_CYCLES != 0);

  entry_t                   fifo_q [DEPTH];
  entry_t                   head;
  logic [DEPTH_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_WIDTH:0]     count_q, count_d;
  logic                     push, pop;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d, wd_inc;
  logic [1:0]               ctrl_opcode_q, ctrl_opcode_d;
  logic [ADDR_WIDTH-1:0]    ctrl_op1_q, ctrl_op1_d;
  logic [ADDR_WIDTH-1:0]    ctrl_op2_q, ctrl_op2_d;
  logic [TAG_WIDTH-1:0]     rsp_tag_q, rsp_tag_d;
  logic [1:0]               rsp_opcode_q, rsp_opcode_d;
  logic                     rsp_timeout_q, rsp_timeout_d;

  // ---------------------------------------------------------------- FIFO
  assign cmd_ready = (count_q < FULL_COUNT);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == ST_ISSUE);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_q[wr_ptr_q] <= '{opcode: cmd_opcode, op1: cmd_op1_addr,
                            op2: cmd_op2_addr, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + TIMEOUT_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    ctrl_opcode_d = ctrl_opcode_q;
    ctrl_op1_d    = ctrl_op1_q;
    ctrl_op2_d    = ctrl_op2_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_opcode_d  = rsp_opcode_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        // Load the controller fields now so they are registered during ISSUE.
        if (count_q != '0) begin
          state_d       = ST_ISSUE;
          ctrl_opcode_d = head.opcode;
          ctrl_op1_d    = head.op1;
          ctrl_op2_d    = head.op2;
        end
      end
      ST_ISSUE: begin
        rsp_tag_d     = head.tag;
        rsp_opcode_d  = head.opcode;
        rsp_timeout_d = 1'b0;
        wd_d          = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        // wd_q is zero only in the first WAIT cycle, where done may be stale.
        if ((wd_q != '0) && ctrl_done) begin
          state_d       = ST_RESP;
          rsp_timeout_d = 1'b0;
        end else begin
          wd_d = wd_inc;
          if (WD_ENABLE && (wd_inc >= WD_LIMIT)) begin
            state_d       = ST_RESP;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      ctrl_opcode_q <= '0;
      ctrl_op1_q    <= '0;
      ctrl_op2_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_opcode_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      ctrl_opcode_q <= ctrl_opcode_d;
      ctrl_op1_q    <= ctrl_op1_d;
      ctrl_op2_q    <= ctrl_op2_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_opcode_q  <= rsp_opcode_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // ------------------------------------------------------------- outputs
  assign ctrl_config_en     = (state_q == ST_ISSUE);
  assign ctrl_opcode        = ctrl_opcode_q;
  assign ctrl_op1_base_addr = ctrl_op1_q;
  assign ctrl_op2_base_addr = ctrl_op2_q;
  assign rsp_valid          = (state_q == ST_RESP);
  assign rsp_tag            = rsp_tag_q;
  assign rsp_opcode         = rsp_opcode_q;
  assign rsp_timeout        = rsp_timeout_q;
  assign busy               = (state_q != ST_IDLE) || (count_q != '0);
  assign queue_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lwe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lwe_cmd_sequencer : scoreboard bench with a controller model for
//                        lwe_cmd_sequencer (watchdog limit 20 cycles).
// Revision 1.0
// ============================================================================
module tb_lwe_cmd_sequencer;

  localparam int AW  = 8;
  localparam int TW  = 4;
  localparam int DW  = 2;
  localparam int TO  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode = '0;
  logic [AW-1:0] cmd_op1_addr = '0;
  logic [AW-1:0] cmd_op2_addr = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          ctrl_config_en;
  logic [1:0]    ctrl_opcode;
  logic [AW-1:0] ctrl_op1_base_addr;
  logic [AW-1:0] ctrl_op2_base_addr;
  logic          ctrl_done = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [TW-1:0] rsp_tag;
  logic [1:0]    rsp_opcode;
  logic          rsp_timeout;
  logic          busy;
  logic [DW:0]   queue_count;

  always #5 clk = ~clk;

  lwe_cmd_sequencer #(
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(4), .DEPTH_WIDTH(DW),
    .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1_addr(cmd_op1_addr), .cmd_op2_addr(cmd_op2_addr), .cmd_tag(cmd_tag),
    .ctrl_config_en(ctrl_config_en), .ctrl_opcode(ctrl_opcode),
    .ctrl_op1_base_addr(ctrl_op1_base_addr), .ctrl_op2_base_addr(ctrl_op2_base_addr),
    .ctrl_done(ctrl_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_opcode(rsp_opcode), .rsp_timeout(rsp_timeout),
    .busy(busy), .queue_count(queue_count)
  );

  typedef struct { logic [TW-1:0] tag; logic [1:0] op; logic to; int lat; } rsp_t;
  typedef struct { logic [1:0] op; logic [AW-1:0] a1; logic [AW-1:0] a2; } cfg_t;

  rsp_t exp_rsp[$];
  cfg_t exp_cfg[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Controller model: done rises ctrl_delay cycles after the configure cycle
  // (0 = never) and the previous done stays high until two cycles after it.
  bit model_en   = 1'b1;
  bit force_done = 1'b0;
  bit cfg_seen   = 1'b0;
  int ctrl_delay = 0;
  int cd_cnt     = 0;

  always @(negedge clk) begin
    if (!model_en) begin
      ctrl_done = force_done;
      cfg_seen  = 1'b0;
    end else if (ctrl_config_en) begin
      cd_cnt   = 0;
      cfg_seen = 1'b1;
    end else if (cfg_seen) begin
      cd_cnt++;
      if (cd_cnt == 2) ctrl_done = 1'b0;
      if (ctrl_delay != 0 && cd_cnt == ctrl_delay) ctrl_done = 1'b1;
      if (cd_cnt >= 2 && (ctrl_delay == 0 || cd_cnt >= ctrl_delay)) cfg_seen = 1'b0;
    end
  end

  // Monitor: configure pulses and responses against the scoreboard queues.
  int   cyc = 0;
  int   cfg_cyc = 0;
  bit   prev_cfg = 1'b0;
  bit   prev_rv = 1'b0;
  cfg_t mc;
  rsp_t mr;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_cfg = 1'b0;
      prev_rv  = 1'b0;
    end else begin
      if (ctrl_config_en) begin
        chk("cfg_single_cycle", prev_cfg, 0);
        if (exp_cfg.size() == 0) begin
          fail_now("cfg_unexpected");
        end else begin
          mc = exp_cfg.pop_front();
          chk("cfg_opcode", ctrl_opcode, mc.op);
          chk("cfg_op1", ctrl_op1_base_addr, mc.a1);
          chk("cfg_op2", ctrl_op2_base_addr, mc.a2);
        end
        cfg_cyc = cyc;
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          mr = exp_rsp[0];
          if (!prev_rv) chk("rsp_latency", cyc - cfg_cyc, mr.lat);
          chk("rsp_tag", rsp_tag, mr.tag);
          chk("rsp_opcode", rsp_opcode, mr.op);
          chk("rsp_timeout", rsp_timeout, mr.to);
          if (rsp_ready) void'(exp_rsp.pop_front());
        end
      end
      prev_cfg = ctrl_config_en;
      prev_rv  = rsp_valid;
    end
  end

  function automatic rsp_t mk_rsp(input logic [TW-1:0] tag, input logic [1:0] op, input int d);
    rsp_t r;
    r.tag = tag;
    r.op  = op;
    if (d != 0 && d <= TO) begin
      r.to  = 1'b0;
      r.lat = d + 1;
    end else begin
      r.to  = 1'b1;
      r.lat = TO + 1;
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [TW-1:0] tag, output int waited);
    cfg_t c;
    int   n = 0;
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_op1_addr = a1;
    cmd_op2_addr = a2;
    cmd_tag = tag;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    waited = n;
    if (!cmd_ready) begin
      fail_now("send_accept_timeout");
    end else begin
      c.op = op; c.a1 = a1; c.a2 = a2;
      exp_cfg.push_back(c);
      exp_rsp.push_back(mk_rsp(tag, op, ctrl_delay));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_rsp.size() != 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_rsp.size() != 0) begin
      fail_now({name, "_drain_timeout"});
      exp_rsp.delete();
      exp_cfg.delete();
    end
    @(negedge clk);
    chk({name, "_busy_idle"}, busy, 0);
    chk({name, "_count_idle"}, queue_count, 0);
    chk({name, "_ready_idle"}, cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cfg_en"}, ctrl_config_en, 0);
    chk({p, "_ctrl_opcode"}, ctrl_opcode, 0);
    chk({p, "_ctrl_op1"}, ctrl_op1_base_addr, 0);
    chk({p, "_ctrl_op2"}, ctrl_op2_base_addr, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_tag"}, rsp_tag, 0);
    chk({p, "_rsp_opcode"}, rsp_opcode, 0);
    chk({p, "_rsp_timeout"}, rsp_timeout, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_count"}, queue_count, 0);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst");

    // Single ADD, done 14 cycles after configure.
    ctrl_delay = 14;
    @(posedge clk); #1;
    send(2'b10, 8'h10, 8'h40, 4'd3, w);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    @(posedge clk); #1;
    drain("t1");
    chk("t1_hold_opcode", ctrl_opcode, 2'b10);
    chk("t1_hold_op1", ctrl_op1_base_addr, 8'h10);
    chk("t1_hold_op2", ctrl_op2_base_addr, 8'h40);

    // Back-to-back commands, done never asserted: FIFO fills, 6th stalls.
    ctrl_delay = 0;
    for (int i = 0; i < 5; i++) begin
      send(2'(i), 8'(8'h20 + i), 8'(8'h80 + i), 4'(4 + i), w);
    end
    @(negedge clk);
    chk("t2_count_full", queue_count, 4);
    chk("t2_ready_full", cmd_ready, 0);
    @(posedge clk); #1;
    send(2'b01, 8'h25, 8'h85, 4'd9, w);
    chk("t2_stall_cycles", w, 20);
    drain("t2");

    // Watchdog, then done exactly on the last watchdog cycle, then just before.
    ctrl_delay = 0;
    send(2'b01, 8'h31, 8'h32, 4'hA, w);
    drain("t3a");
    ctrl_delay = 20;
    send(2'b11, 8'h33, 8'h34, 4'hB, w);
    drain("t3b");
    ctrl_delay = 19;
    send(2'b00, 8'h35, 8'h36, 4'hC, w);
    drain("t3c");

    // Response back-pressure with two commands queued.
    rsp_ready = 1'b0;
    ctrl_delay = 4;
    send(2'b10, 8'h41, 8'h42, 4'hD, w);
    send(2'b11, 8'h43, 8'h44, 4'hE, w);
    send(2'b00, 8'h45, 8'h46, 4'hF, w);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) fail_now("t4_rsp_wait_timeout");
    chk("t4_count_queued", queue_count, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_no_cfg", ctrl_config_en, 0);
      chk("t4_hold_valid", rsp_valid, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_valid", rsp_valid, 1);
    chk("t4_hs_no_cfg", ctrl_config_en, 0);
    @(negedge clk);
    chk("t4_idle_valid", rsp_valid, 0);
    chk("t4_idle_no_cfg", ctrl_config_en, 0);
    @(negedge clk);
    chk("t4_next_cfg", ctrl_config_en, 1);
    @(posedge clk); #1;
    drain("t4");

    // In-order responses; stale done must not complete the next op.
    ctrl_delay = 5;
    send(2'b00, 8'h51, 8'h52, 4'd1, w);
    send(2'b01, 8'h53, 8'h54, 4'd2, w);
    send(2'b11, 8'h55, 8'h56, 4'd3, w);
    drain("t5");

    // Reset during WAIT with three queued, done stuck high afterwards.
    ctrl_delay = 0;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 8'(8'h60 + i), 8'(8'h70 + i), 4'(i + 5), w);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_count", queue_count, 3);
    chk("t6_pre_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_en = 1'b0;
    force_done = 1'b1;
    exp_rsp.delete();
    exp_cfg.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_in_rst_count", queue_count, 0);
    chk("t6_in_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("t6_rel");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_quiet_valid", rsp_valid, 0);
      chk("t6_quiet_cfg", ctrl_config_en, 0);
      chk("t6_quiet_count", queue_count, 0);
    end
    model_en = 1'b1;
    ctrl_delay = 8;
    @(posedge clk); #1;
    send(2'b10, 8'h77, 8'h78, 4'd6, w);
    drain("t6");

    chk("end_rsp_queue_empty", exp_rsp.size(), 0);
    chk("end_cfg_queue_empty", exp_cfg.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
